tlb: RTL and testbench

Responder side of the CP0↔TLB interface in the MIPS core.
- Holds `TLB_ENTRIES_NUM` tlb_entry_t entries.
- Services TLBR/TLBWI from CP0.
- Runs TLBP probes against CP0's EntryHi.
- Provides two registered address-translation ports (fetch, data) to the MMU.
- Sits beside CP0; connects to it through the TLB modport of C0_TLB_Interface.

---
 rtl/tlb_pkg.sv | 56 +++++
 rtl/c0_tlb_if.sv | 23 ++
 rtl/tlb_lookup.sv | 62 ++++++
 rtl/tlb.sv | 84 ++++++++
 tb/tb_tlb.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB types: entry layout, translation result, and the match and offset helpers.
// Every file of the TLB slice imports this package.
package tlb_pkg;

  localparam int TLB_ENTRIES_NUM = 16;
  localparam int TLB_INDEX_W     = $clog2(TLB_ENTRIES_NUM);

  typedef logic [31:0]            virt_t;
  typedef logic [31:0]            phys_t;
  typedef logic [TLB_INDEX_W-1:0] tlb_index_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    phys_t      phy_addr;
    tlb_index_t which;
    logic       miss;
    logic       valid;
    logic       dirty;
    logic [2:0] cache_flag;
  } tlb_result_t;

  // A miss carries no translation at all, which is also the reset value of the ports.
  localparam tlb_result_t TLB_RESULT_MISS = '{
    phy_addr:   '0,
    which:      '0,
    miss:       1'b1,
    valid:      1'b0,
    dirty:      1'b0,
    cache_flag: 3'b000
  };

  function automatic logic tlb_match(tlb_entry_t e, logic [18:0] vpn2, logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  function automatic tlb_result_t tlb_fill_offset(tlb_result_t r, virt_t vaddr);
    tlb_result_t o;
    o = r;
    if (!r.miss) o.phy_addr[11:0] = vaddr[11:0];
    return o;
  endfunction

endpackage

// File: rtl/c0_tlb_if.sv
// Signals exchanged between CP0 and the TLB. CP0 drives the TLBR/TLBWI/TLBP requests;
// the TLB answers with the read entry and the probe result.
interface C0_TLB_Interface;
  import tlb_pkg::*;

  tlb_index_t  tlbrw_index;
  logic        tlbrw_we;
  tlb_entry_t  tlbrw_wdata;
  tlb_entry_t  tlbrw_rdata;
  logic [31:0] tlbp_entry_hi;
  logic [31:0] tlbp_index;

  modport TLB (
    input  tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
    output tlbrw_rdata, tlbp_index
  );

  modport CP0 (
    output tlbrw_index, tlbrw_we, tlbrw_wdata, tlbp_entry_hi,
    input  tlbrw_rdata, tlbp_index
  );

endinterface

// File: rtl/tlb_lookup.sv
// Combinational TLB search: match all entries, pick the lowest matching index, select the page half.
// phy_addr carries only the frame number; the caller supplies the page offset.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int N_ENTRIES = TLB_ENTRIES_NUM
) (
  input  tlb_entry_t  entries [N_ENTRIES],
  input  logic [18:0] vpn2,
  input  logic        odd,
  input  logic [7:0]  asid,
  output tlb_result_t result
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  logic [N_ENTRIES-1:0] match;
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  tlb_entry_t           sel;

  always_comb begin
    match = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      match[i] = tlb_match(entries[i], vpn2, asid);
    end
  end

  // The loop runs downward, so the lowest matching index is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign sel = entries[hit_idx];

  always_comb begin
    result = TLB_RESULT_MISS;
    if (hit) begin
      result.miss  = 1'b0;
      result.which = tlb_index_t'(hit_idx);
      if (odd) begin
        result.phy_addr   = {sel.pfn1, 12'h000};
        result.valid      = sel.v1;
        result.dirty      = sel.d1;
        result.cache_flag = sel.c1;
      end else begin
        result.phy_addr   = {sel.pfn0, 12'h000};
        result.valid      = sel.v0;
        result.dirty      = sel.d0;
        result.cache_flag = sel.c0;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// TLB responder: entry array, TLBR/TLBWI port, TLBP probe register and two registered
// translation ports. All searches see the array as it was before a same-edge write.
module tlb
  import tlb_pkg::*;
#(
  parameter int N_ENTRIES = TLB_ENTRIES_NUM
) (
  input  logic              clk,
  input  logic              rst,
  C0_TLB_Interface.TLB      c0,
  input  logic              inst_req,
  input  virt_t             inst_vaddr,
  input  logic              data_req,
  input  virt_t             data_vaddr,
  input  logic [7:0]        asid,
  output tlb_result_t       inst_result,
  output tlb_result_t       data_result
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  tlb_entry_t       entries [N_ENTRIES];
  logic [IDX_W-1:0] rw_idx;
  tlb_result_t      inst_lu;
  tlb_result_t      data_lu;
  tlb_result_t      probe_lu;
  logic [31:0]      probe_q;
  logic             probe_unused;

  assign rw_idx = c0.tlbrw_index[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) entries[i] <= '0;
    end else if (c0.tlbrw_we) begin
      entries[rw_idx] <= c0.tlbrw_wdata;
    end
  end

  assign c0.tlbrw_rdata = entries[rw_idx];

  tlb_lookup #(.N_ENTRIES(N_ENTRIES)) u_inst_lookup (
    .entries (entries),
    .vpn2    (inst_vaddr[31:13]),
    .odd     (inst_vaddr[12]),
    .asid    (asid),
    .result  (inst_lu)
  );

  tlb_lookup #(.N_ENTRIES(N_ENTRIES)) u_data_lookup (
    .entries (entries),
    .vpn2    (data_vaddr[31:13]),
    .odd     (data_vaddr[12]),
    .asid    (asid),
    .result  (data_lu)
  );

  tlb_lookup #(.N_ENTRIES(N_ENTRIES)) u_probe_lookup (
    .entries (entries),
    .vpn2    (c0.tlbp_entry_hi[31:13]),
    .odd     (1'b0),
    .asid    (c0.tlbp_entry_hi[7:0]),
    .result  (probe_lu)
  );

  // The probe needs only miss/which; the remaining fields and EntryHi[12:8] are don't-care.
  assign probe_unused = ^{probe_lu.phy_addr, probe_lu.valid, probe_lu.dirty,
                          probe_lu.cache_flag, c0.tlbp_entry_hi[12:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_result <= TLB_RESULT_MISS;
      data_result <= TLB_RESULT_MISS;
      probe_q     <= 32'h8000_0000;
    end else begin
      if (inst_req) inst_result <= tlb_fill_offset(inst_lu, inst_vaddr);
      if (data_req) data_result <= tlb_fill_offset(data_lu, data_vaddr);
      probe_q <= probe_lu.miss ? 32'h8000_0000 : 32'(probe_lu.which);
    end
  end

  assign c0.tlbp_index = probe_q;

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed scenarios plus randomized traffic against
// an array-based reference model of the TLB rules.
module tb_tlb;
  import tlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req;
  virt_t       inst_vaddr, data_vaddr;
  logic [7:0]  asid;
  tlb_result_t inst_result, data_result;

  C0_TLB_Interface c0_if();

  tlb dut (
    .clk         (clk),
    .rst         (rst),
    .c0          (c0_if.TLB),
    .inst_req    (inst_req),
    .inst_vaddr  (inst_vaddr),
    .data_req    (data_req),
    .data_vaddr  (data_vaddr),
    .asid        (asid),
    .inst_result (inst_result),
    .data_result (data_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  tlb_entry_t  mdl [16];
  tlb_result_t exp_inst, exp_data;
  logic [31:0] exp_probe;
  tlb_result_t reset_res;

  function automatic tlb_result_t ref_lookup(virt_t va, logic [7:0] as);
    tlb_result_t r;
    r.phy_addr = 32'h0; r.which = '0; r.miss = 1'b1;
    r.valid = 1'b0; r.dirty = 1'b0; r.cache_flag = 3'b0;
    for (int i = 0; i < 16; i++) begin
      if (mdl[i].vpn2 == va[31:13] && (mdl[i].g || mdl[i].asid == as)) begin
        r.miss  = 1'b0;
        r.which = 4'(i);
        if (va[12]) begin
          r.phy_addr = {mdl[i].pfn1, va[11:0]};
          r.valid = mdl[i].v1; r.dirty = mdl[i].d1; r.cache_flag = mdl[i].c1;
        end else begin
          r.phy_addr = {mdl[i].pfn0, va[11:0]};
          r.valid = mdl[i].v0; r.dirty = mdl[i].d0; r.cache_flag = mdl[i].c0;
        end
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_probe(logic [31:0] hi);
    for (int i = 0; i < 16; i++) begin
      if (mdl[i].vpn2 == hi[31:13] && (mdl[i].g || mdl[i].asid == hi[7:0])) return 32'(i);
    end
    return 32'h8000_0000;
  endfunction

  function automatic logic [18:0] pick_vpn();
    case ($urandom_range(0, 3))
      0: return 19'h00040;
      1: return 19'h00041;
      2: return 19'h12345;
      default: return 19'h0ABCD;
    endcase
  endfunction

  function automatic logic [7:0] pick_asid();
    case ($urandom_range(0, 2))
      0: return 8'h05;
      1: return 8'h06;
      default: return 8'h22;
    endcase
  endfunction

  function automatic tlb_entry_t rand_entry();
    tlb_entry_t e;
    e.vpn2 = pick_vpn();
    e.asid = pick_asid();
    e.g    = ($urandom_range(0, 3) == 0);
    e.pfn0 = 20'($urandom); e.c0 = 3'($urandom); e.d0 = 1'($urandom); e.v0 = 1'($urandom);
    e.pfn1 = 20'($urandom); e.c1 = 3'($urandom); e.d1 = 1'($urandom); e.v1 = 1'($urandom);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle, keeping the model in step with the inputs applied during it.
  task automatic step();
    tlb_result_t ni, nd;
    logic [31:0] np;
    ni = ref_lookup(inst_vaddr, asid);
    nd = ref_lookup(data_vaddr, asid);
    np = ref_probe(c0_if.tlbp_entry_hi);
    tick();
    if (rst) begin
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      exp_inst = reset_res; exp_data = reset_res; exp_probe = 32'h8000_0000;
    end else begin
      if (inst_req) exp_inst = ni;
      if (data_req) exp_data = nd;
      exp_probe = np;
      if (c0_if.tlbrw_we) mdl[c0_if.tlbrw_index] = c0_if.tlbrw_wdata;
    end
  endtask

  task automatic idle();
    c0_if.tlbrw_we = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    step();
    step();
    rst = 1'b0;
    checks++; if (inst_result !== reset_res) begin errors++; $display("FAIL reset_inst: got %h expected %h", inst_result, reset_res); end
    checks++; if (data_result !== reset_res) begin errors++; $display("FAIL reset_data: got %h expected %h", data_result, reset_res); end
    checks++; if (c0_if.tlbp_index !== 32'h8000_0000) begin errors++; $display("FAIL reset_probe: got %h expected 80000000", c0_if.tlbp_index); end
    for (int i = 0; i < 16; i += 5) begin
      c0_if.tlbrw_index = 4'(i); #1;
      checks++; if (c0_if.tlbrw_rdata !== '0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0", i, c0_if.tlbrw_rdata); end
    end
  endtask

  tlb_entry_t ent3;

  task automatic test_write_read();
    ent3 = '0;
    ent3.vpn2 = 19'h00040; ent3.asid = 8'h05; ent3.g = 1'b0;
    ent3.pfn1 = 20'h12345; ent3.v1 = 1'b1; ent3.d1 = 1'b1; ent3.c1 = 3'd3;
    ent3.pfn0 = 20'h0ABCD; ent3.v0 = 1'b0; ent3.d0 = 1'b1; ent3.c0 = 3'd2;
    c0_if.tlbrw_index = 4'd3; c0_if.tlbrw_wdata = ent3; c0_if.tlbrw_we = 1'b1;
    #1;
    checks++; if (c0_if.tlbrw_rdata !== '0) begin errors++; $display("FAIL rdata_before_write: got %h expected 0", c0_if.tlbrw_rdata); end
    step();
    c0_if.tlbrw_we = 1'b0;
    checks++; if (c0_if.tlbrw_rdata !== ent3) begin errors++; $display("FAIL rdata_after_write: got %h expected %h", c0_if.tlbrw_rdata, ent3); end
  endtask

  task automatic test_lookup();
    data_req = 1'b1; data_vaddr = 32'h0008_1ABC; asid = 8'h05;
    step();
    data_req = 1'b0;
    checks++; if (data_result.phy_addr !== 32'h1234_5ABC || data_result.which !== 4'd3 ||
                  data_result.valid !== 1'b1 || data_result.dirty !== 1'b1 ||
                  data_result.cache_flag !== 3'd3 || data_result.miss !== 1'b0) begin
      errors++; $display("FAIL lookup_odd_hit: got %h expected phy 12345abc which 3 v1 d1 c3", data_result);
    end
    checks++; if (data_result !== exp_data) begin errors++; $display("FAIL lookup_odd_model: got %h expected %h", data_result, exp_data); end

    inst_req = 1'b1; inst_vaddr = 32'h0008_1ABC; asid = 8'h06;
    step();
    inst_req = 1'b0;
    checks++; if (inst_result.miss !== 1'b1) begin errors++; $display("FAIL lookup_asid_miss: got miss %b expected 1", inst_result.miss); end
    checks++; if (data_result !== exp_data) begin errors++; $display("FAIL lookup_data_held: got %h expected %h", data_result, exp_data); end

    ent3.g = 1'b1;
    c0_if.tlbrw_index = 4'd3; c0_if.tlbrw_wdata = ent3; c0_if.tlbrw_we = 1'b1;
    step();
    c0_if.tlbrw_we = 1'b0;
    inst_req = 1'b1; inst_vaddr = 32'h0008_1ABC; asid = 8'h06;
    data_req = 1'b1; data_vaddr = 32'h0008_0ABC;
    step();
    idle();
    checks++; if (inst_result.miss !== 1'b0 || inst_result.which !== 4'd3) begin errors++; $display("FAIL lookup_global_hit: got %h expected hit which 3", inst_result); end
    checks++; if (data_result.miss !== 1'b0 || data_result.valid !== 1'b0 || data_result.phy_addr !== 32'h0ABC_DABC) begin
      errors++; $display("FAIL lookup_even_invalid: got %h expected hit valid 0 phy 0abcdabc", data_result);
    end
    checks++; if (data_result !== exp_data) begin errors++; $display("FAIL lookup_even_model: got %h expected %h", data_result, exp_data); end
  endtask

  task automatic test_probe();
    c0_if.tlbp_entry_hi = 32'h0008_0005;
    step();
    checks++; if (c0_if.tlbp_index !== 32'd3) begin errors++; $display("FAIL probe_hit: got %h expected 3", c0_if.tlbp_index); end
    c0_if.tlbp_entry_hi = 32'h0008_2005;
    step();
    checks++; if (c0_if.tlbp_index !== 32'h8000_0000) begin errors++; $display("FAIL probe_miss: got %h expected 80000000", c0_if.tlbp_index); end
  endtask

  task automatic test_write_lookup_same_cycle();
    tlb_entry_t e;
    e = '0;
    e.vpn2 = 19'h12345; e.asid = 8'h22; e.pfn0 = 20'hFEDCB; e.v0 = 1'b1;
    c0_if.tlbrw_index = 4'd7; c0_if.tlbrw_wdata = e; c0_if.tlbrw_we = 1'b1;
    inst_req = 1'b1; inst_vaddr = {19'h12345, 1'b0, 12'h123}; asid = 8'h22;
    c0_if.tlbp_entry_hi = {19'h12345, 5'd0, 8'h22};
    step();
    c0_if.tlbrw_we = 1'b0;
    checks++; if (inst_result.miss !== 1'b1) begin errors++; $display("FAIL same_edge_lookup: got miss %b expected 1", inst_result.miss); end
    checks++; if (c0_if.tlbp_index !== 32'h8000_0000) begin errors++; $display("FAIL same_edge_probe: got %h expected 80000000", c0_if.tlbp_index); end
    step();
    inst_req = 1'b0;
    checks++; if (inst_result.miss !== 1'b0 || inst_result.which !== 4'd7 || inst_result.phy_addr !== 32'hFEDC_B123) begin
      errors++; $display("FAIL next_edge_lookup: got %h expected hit which 7 phy fedcb123", inst_result);
    end
    checks++; if (c0_if.tlbp_index !== 32'd7) begin errors++; $display("FAIL next_edge_probe: got %h expected 7", c0_if.tlbp_index); end
  endtask

  task automatic test_priority();
    tlb_entry_t e;
    e = rand_entry();
    e.vpn2 = 19'h0ABCD; e.asid = 8'h33; e.g = 1'b0;
    c0_if.tlbrw_index = 4'd9; c0_if.tlbrw_wdata = e; c0_if.tlbrw_we = 1'b1;
    step();
    e.pfn1 = e.pfn1 ^ 20'h5A5A5;
    c0_if.tlbrw_index = 4'd2; c0_if.tlbrw_wdata = e;
    step();
    c0_if.tlbrw_we = 1'b0;
    data_req = 1'b1; data_vaddr = {19'h0ABCD, 1'b1, 12'h777}; asid = 8'h33;
    step();
    data_req = 1'b0;
    checks++; if (data_result.which !== 4'd2) begin errors++; $display("FAIL priority_which: got %0d expected 2", data_result.which); end
    checks++; if (data_result !== exp_data) begin errors++; $display("FAIL priority_model: got %h expected %h", data_result, exp_data); end
  endtask

  task automatic test_hold();
    tlb_entry_t  e;
    tlb_result_t held;
    inst_req = 1'b1; inst_vaddr = {19'h0ABCD, 1'b1, 12'h0F0}; asid = 8'h33;
    step();
    inst_req = 1'b0;
    held = exp_inst;
    for (int k = 0; k < 5; k++) begin
      e = rand_entry();
      e.vpn2 = 19'h0ABCD; e.g = 1'b1;
      c0_if.tlbrw_index = (k == 0) ? 4'd2 : 4'(k - 1);
      c0_if.tlbrw_wdata = e; c0_if.tlbrw_we = 1'b1;
      inst_vaddr = 32'($urandom);
      step();
      checks++; if (inst_result !== held) begin errors++; $display("FAIL hold_cycle%0d: got %h expected %h", k, inst_result, held); end
    end
    c0_if.tlbrw_we = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      c0_if.tlbrw_we      = ($urandom_range(0, 2) == 0);
      c0_if.tlbrw_index   = 4'($urandom);
      c0_if.tlbrw_wdata   = rand_entry();
      inst_req            = 1'($urandom);
      data_req            = 1'($urandom);
      inst_vaddr          = {pick_vpn(), 13'($urandom)};
      data_vaddr          = {pick_vpn(), 13'($urandom)};
      asid                = pick_asid();
      c0_if.tlbp_entry_hi = {pick_vpn(), 5'($urandom), pick_asid()};
      step();
      checks++; if (inst_result !== exp_inst) begin errors++; $display("FAIL rand_inst@%0d: got %h expected %h", k, inst_result, exp_inst); end
      checks++; if (data_result !== exp_data) begin errors++; $display("FAIL rand_data@%0d: got %h expected %h", k, data_result, exp_data); end
      checks++; if (c0_if.tlbp_index !== exp_probe) begin errors++; $display("FAIL rand_probe@%0d: got %h expected %h", k, c0_if.tlbp_index, exp_probe); end
      checks++; if (c0_if.tlbrw_rdata !== mdl[c0_if.tlbrw_index]) begin
        errors++; $display("FAIL rand_rdata@%0d: got %h expected %h", k, c0_if.tlbrw_rdata, mdl[c0_if.tlbrw_index]);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    tlb_entry_t e;
    e = rand_entry();
    e.vpn2 = 19'h00040; e.g = 1'b1;
    c0_if.tlbrw_index = 4'd5; c0_if.tlbrw_wdata = e; c0_if.tlbrw_we = 1'b1;
    inst_req = 1'b1; data_req = 1'b1;
    inst_vaddr = 32'h0008_1ABC; data_vaddr = 32'h0008_0ABC;
    c0_if.tlbp_entry_hi = 32'h0008_0005;
    rst = 1'b1;
    step();
    rst = 1'b0; idle();
    checks++; if (inst_result !== reset_res) begin errors++; $display("FAIL midrst_inst: got %h expected %h", inst_result, reset_res); end
    checks++; if (data_result !== reset_res) begin errors++; $display("FAIL midrst_data: got %h expected %h", data_result, reset_res); end
    checks++; if (c0_if.tlbp_index !== 32'h8000_0000) begin errors++; $display("FAIL midrst_probe: got %h expected 80000000", c0_if.tlbp_index); end
    checks++; if (c0_if.tlbrw_rdata !== '0) begin errors++; $display("FAIL midrst_rdata5: got %h expected 0", c0_if.tlbrw_rdata); end
    inst_req = 1'b1;
    step();
    inst_req = 1'b0;
    checks++; if (inst_result.miss !== 1'b1) begin errors++; $display("FAIL midrst_cleared: got miss %b expected 1", inst_result.miss); end
    checks++; if (c0_if.tlbp_index !== 32'h8000_0000) begin errors++; $display("FAIL midrst_probe_after: got %h expected 80000000", c0_if.tlbp_index); end
  endtask

  initial begin
    reset_res = '0;
    reset_res.miss = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    exp_inst = reset_res; exp_data = reset_res; exp_probe = 32'h8000_0000;
    rst = 1'b1;
    c0_if.tlbrw_index = '0; c0_if.tlbrw_we = 1'b0; c0_if.tlbrw_wdata = '0;
    c0_if.tlbp_entry_hi = 32'h0;
    inst_req = 1'b0; data_req = 1'b0;
    inst_vaddr = 32'h0; data_vaddr = 32'h0; asid = 8'h00;
    test_reset();
    test_write_read();
    test_lookup();
    test_probe();
    test_write_lookup_same_cycle();
    test_priority();
    test_hold();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
